// File: rtl/i2c_pkg.sv
// Shared I2C definitions: capture-record field offsets and bus-FSM state encodings.
package i2c_pkg;

  localparam int unsigned START_BIT = 9;
  localparam int unsigned ACK_BIT   = 8;
  localparam int unsigned REC_W     = 10;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_BIT_WAIT  = 2'd2,
    ST_BYTE_DONE = 2'd3
  } i2c_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with drop-on-full and a same-cycle drop indication.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_wr = wr_en & (~full | do_rd);
  assign drop  = wr_en & full & ~do_rd;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_sniffer.sv
// Passive I2C bus monitor: filters SCL/SDA, decodes START/STOP/bytes, raises an address
// trigger and captures {start_flag, ack_bit, data} records into a FIFO.
module i2c_sniffer
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN   = 3,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          scl_in,
  input  logic                          sda_in,
  input  logic                          match_en,
  input  logic [6:0]                    match_addr,
  input  logic                          match_rw,
  input  logic                          rd_en,
  output logic [9:0]                    rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sop,
  output logic                          eot,
  output logic                          trigger,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          busy
);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      filt;
  logic [1:0]      filt_d;
  logic [1:0][3:0] fcnt;

  logic            scl_rise;
  logic            start_det;
  logic            stop_det;
  logic            sda_smp;

  i2c_state_t      state;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            start_flag;
  logic            ack_bit;
  logic            trig_armed;
  logic [7:0]      key;

  logic            push;
  logic [REC_W-1:0] push_rec;
  logic            fifo_drop;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      fcnt   <= '0;
    end else begin
      sync1  <= {sda_in, scl_in};
      sync2  <= sync1;
      filt_d <= filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 4'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      scl_rise  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_smp   <= 1'b0;
    end else begin
      scl_rise  <= filt[0] & ~filt_d[0];
      start_det <= filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
      stop_det  <= filt[0] & filt_d[0] & ~filt_d[1] & filt[1];
      sda_smp   <= filt[1];
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      bit_cnt    <= '0;
      shreg      <= '0;
      start_flag <= 1'b0;
      ack_bit    <= 1'b0;
      busy       <= 1'b0;
      sop        <= 1'b0;
      eot        <= 1'b0;
      trigger    <= 1'b0;
      trig_armed <= 1'b0;
      key        <= '0;
    end else begin
      sop     <= 1'b0;
      eot     <= 1'b0;
      trigger <= 1'b0;
      if (state == ST_INIT) begin
        if (filt[0] && filt[1]) state <= ST_IDLE;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        eot     <= 1'b1;
        busy    <= 1'b0;
      end else if (start_det) begin
        state      <= ST_BIT_WAIT;
        bit_cnt    <= '0;
        start_flag <= 1'b1;
        sop        <= 1'b1;
        busy       <= 1'b1;
        trig_armed <= match_en;
        key        <= {match_addr, match_rw};
      end else begin
        case (state)
          ST_BIT_WAIT: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd8) begin
                ack_bit <= sda_smp;
                state   <= ST_BYTE_DONE;
              end else begin
                shreg   <= {shreg[6:0], sda_smp};
                bit_cnt <= bit_cnt + 4'd1;
                // Only the first byte after a START may trigger; disarm once it is complete.
                if (bit_cnt == 4'd7) begin
                  trig_armed <= 1'b0;
                  if (trig_armed && ({shreg[6:0], sda_smp} == key)) trigger <= 1'b1;
                end
              end
            end
          end
          ST_BYTE_DONE: begin
            start_flag <= 1'b0;
            bit_cnt    <= '0;
            state      <= ST_BIT_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    push_rec            = '0;
    push_rec[START_BIT] = start_flag;
    push_rec[ACK_BIT]   = ack_bit;
    push_rec[7:0]       = shreg;
    push                = (state == ST_BYTE_DONE);
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_rec),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)         ovf <= 1'b0;
    else if (fifo_drop) ovf <= 1'b1;
    else if (ovf_clr)   ovf <= 1'b0;
  end

endmodule

// File: doc/i2c_sniffer.md
I2C_SNIFFER -- requirements
Module: i2c_sniffer

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive equal synchronised samples required before a filtered SCL/SDA level changes (1..15).
REQ-002 Parameter FIFO_DEPTH, default 16: capture-FIFO entries; power of two, 4..256.
REQ-003 Ports, one clock domain: `sysclk` in 1, the only clock; `rst_n` in 1, reset, asynchronous and active-low.
REQ-004 `scl_in` in 1 / `sda_in` in 1: raw, asynchronous bus lines; the block only listens and never drives them.
REQ-005 `match_en` in 1 / `match_addr` in 7 / `match_rw` in 1: address-trigger configuration, sampled when a START is detected.
REQ-006 `rd_en` in 1: pop the FIFO head.
REQ-007 `rd_data` out 10: FIFO head record {start_flag, ack_bit, data[7:0]}.
REQ-008 `fifo_empty` out 1 / `fifo_full` out 1 / `fifo_count` out $clog2(FIFO_DEPTH)+1: FIFO status.
REQ-009 `sop` / `eot` / `trigger` out 1: single-cycle pulses.
REQ-010 `ovf` out 1: sticky overflow flag. `ovf_clr` in 1: clears `ovf`.
REQ-011 `busy` out 1: high between START and STOP.

Function
REQ-012 Each line: 2-flop synchroniser, then a stability filter; the filtered level changes only after FILT_LEN consecutive equal samples.
REQ-013 Edge detection on the filtered lines is registered; the event latency from a raw edge is 2+FILT_LEN+1 sysclk cycles.
REQ-014 FSM states: INIT, IDLE, BIT_WAIT, BYTE_DONE.
REQ-015 INIT: exit to IDLE when filtered SCL=1 and SDA=1 for one cycle.
REQ-016 START (SDA falls while SCL=1) in IDLE, BIT_WAIT or BYTE_DONE: go to BIT_WAIT, clear the bit counter, set pending start_flag, pulse `sop`, set `busy`.
REQ-017 STOP (SDA rises while SCL=1) in any non-INIT state: go to IDLE, pulse `eot`, clear `busy`, discard any partial byte (no FIFO push).
REQ-018 BIT_WAIT: each SCL rising edge shifts SDA in MSB-first and increments the bit counter (0..8); the 9th edge captures `ack_bit` and enters BYTE_DONE.
REQ-019 BYTE_DONE: lasts one cycle; pushes {start_flag, ack_bit, data}, clears start_flag, clears the counter, returns to BIT_WAIT.
REQ-020 Trigger: when `match_en` is set at START, and the first byte after that START has data[7:1]==match_addr and data[0]==match_rw, pulse `trigger` on the cycle the 8th SCL rising edge is processed, before the ACK bit.
REQ-021 Trigger fires at most once per START; a repeated START re-arms it.
REQ-022 FIFO: push while full drops the new record and sets `ovf`.
REQ-023 FIFO: simultaneous push and pop while full both succeed and `fifo_count` is unchanged.
REQ-024 FIFO: `rd_en` while empty is ignored.
REQ-025 FIFO: `rd_data` is first-word-fall-through, valid whenever `fifo_empty`=0.
REQ-026 `ovf_clr` and a same-cycle overflow: the overflow wins and `ovf` stays 1.
REQ-027 Pointers wrap modulo FIFO_DEPTH.
REQ-028 `fifo_count` ranges 0..FIFO_DEPTH.

Reset
REQ-029 `rst_n` low asynchronously forces: state=INIT; filtered and synchronised lines=1; the counter and shift register=0.
REQ-030 During and after reset, all FIFO pointers and `fifo_count` are 0; `fifo_empty`=1; `fifo_full`=0.
REQ-031 During and after reset, `ovf`, `busy`, `sop`, `eot` and `trigger` are 0; `rd_data`=0.
REQ-032 Reset asserted mid-byte discards the partial byte and all FIFO contents; after release, the block re-enters via INIT.

Structure
REQ-033 Record field offsets (START_BIT=9, ACK_BIT=8) and the FSM state encodings live in a shared i2c package for reuse by the future master and slave blocks.
REQ-034 The capture FIFO is one sub-module, `sync_fifo` (parameters WIDTH, DEPTH); the synchroniser/filter stays inline.

Verification
REQ-035 START, byte 0xA4, ACK, STOP -> one record 0x2A4 (start=1, ack=0); one `sop` pulse, one `eot` pulse.
REQ-036 match_en=1, match_addr=0x52, match_rw=0, byte 0xA4 -> `trigger` pulses exactly once, after the 8th SCL rise and before the 9th; with match_addr=0x53 -> no pulse.
REQ-037 START, 0xA4/ACK, repeated START, 0xA5/NAK, STOP -> records 0x2A4 then 0x3A5; `trigger` re-armed on the second START.
REQ-038 1-cycle SDA spikes while SCL=1 with FILT_LEN=3 -> no `sop`/`eot`, no records.
REQ-039 FIFO_DEPTH=4, 6 bytes with no reads -> `fifo_count`=4, `ovf`=1, first 4 bytes retained; `ovf_clr` -> `ovf`=0.
REQ-040 `rst_n` pulsed low after 5 SCL bits of a byte -> `fifo_empty`=1 and `busy`=0; the next full transaction is captured correctly.
